// File: rtl/graph_mem_arbiter.sv
// Round-robin arbiter sharing one fixed-latency graph-memory read port among N fetch units.
// Per-requester queues absorb read pulses; a tag pipeline routes returned words to their issuer.
module graph_mem_arbiter #(
  parameter int N      = 4,
  parameter int AW     = 32,
  parameter int DW     = 32,
  parameter int LAT    = 2,
  parameter int QDEPTH = 2
) (
  input  logic            clk_in,
  input  logic            rst_in,
  input  logic [N-1:0]    req_valid_in,
  input  logic [N*AW-1:0] req_addr_in,
  output logic [N-1:0]    resp_valid_out,
  output logic [DW-1:0]   resp_data_out,
  output logic [AW-1:0]   mem_req_out,
  output logic            mem_valid_out,
  input  logic [DW-1:0]   mem_data_in,
  output logic [N-1:0]    overflow_out,
  output logic            busy_out
);

  localparam int IW = $clog2(N);
  localparam int PW = $clog2(QDEPTH);
  localparam int CW = PW + 1;

  logic [AW-1:0] q_mem_r [N][QDEPTH];
  logic [PW-1:0] wr_ptr_r [N];
  logic [PW-1:0] rd_ptr_r [N];
  logic [CW-1:0] cnt_r [N];
  logic [N-1:0]  overflow_r;

  logic [N-1:0]  nonempty_s;
  logic [N-1:0]  deq_s;
  logic [N-1:0]  push_s;
  logic [N-1:0]  drop_s;
  logic          grant_vld_s;
  logic [IW-1:0] grant_id_s;
  logic [AW-1:0] head_s;

  logic [IW-1:0] last_grant_r;
  logic          mem_valid_r;
  logic [AW-1:0] mem_req_r;
  logic [IW-1:0] mem_id_r;
  logic [LAT-1:0] tag_vld_r;
  logic [IW-1:0] tag_id_r [LAT];

  // Queue occupancy flags feeding the arbiter
  always_comb begin
    nonempty_s = '0;
    for (int i = 0; i < N; i++) begin
      nonempty_s[i] = (cnt_r[i] != '0);
    end
  end

  // Round-robin search starting just after the last winner
  always_comb begin
    int  idx_v;
    logic hit_v;
    grant_vld_s = 1'b0;
    grant_id_s  = '0;
    for (int k = 1; k <= N; k++) begin
      idx_v       = (int'(last_grant_r) + k) % N;
      hit_v       = !grant_vld_s && nonempty_s[idx_v];
      grant_id_s  = hit_v ? IW'(idx_v) : grant_id_s;
      grant_vld_s = grant_vld_s | hit_v;
    end
  end

  // Per-queue push/pop/drop decisions; a full queue popped this edge still accepts a push
  always_comb begin
    logic full_v;
    deq_s  = '0;
    push_s = '0;
    drop_s = '0;
    for (int i = 0; i < N; i++) begin
      full_v    = (cnt_r[i] == CW'(QDEPTH));
      deq_s[i]  = grant_vld_s && (grant_id_s == IW'(i));
      push_s[i] = req_valid_in[i] && (!full_v || deq_s[i]);
      drop_s[i] = req_valid_in[i] && full_v && !deq_s[i];
    end
  end

  assign head_s = q_mem_r[grant_id_s][rd_ptr_r[grant_id_s]];

  // Queue storage, written without reset
  always_ff @(posedge clk_in) begin
    for (int i = 0; i < N; i++) begin
      if (push_s[i]) begin
        q_mem_r[i][wr_ptr_r[i]] <= req_addr_in[i*AW +: AW];
      end
    end
  end

  // Queue pointers, counts and sticky overflow flags
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      for (int i = 0; i < N; i++) begin
        wr_ptr_r[i] <= '0;
        rd_ptr_r[i] <= '0;
        cnt_r[i]    <= '0;
      end
      overflow_r <= '0;
    end else begin
      for (int i = 0; i < N; i++) begin
        if (push_s[i]) begin
          wr_ptr_r[i] <= wr_ptr_r[i] + PW'(1);
        end
        if (deq_s[i]) begin
          rd_ptr_r[i] <= rd_ptr_r[i] + PW'(1);
        end
        cnt_r[i] <= cnt_r[i] + CW'(push_s[i]) - CW'(deq_s[i]);
        if (drop_s[i]) begin
          overflow_r[i] <= 1'b1;
        end
      end
    end
  end

  // Memory request register and round-robin pointer
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      mem_valid_r  <= 1'b0;
      mem_req_r    <= '0;
      mem_id_r     <= '0;
      last_grant_r <= IW'(N - 1);
    end else begin
      mem_valid_r <= grant_vld_s;
      if (grant_vld_s) begin
        mem_req_r    <= head_s;
        mem_id_r     <= grant_id_s;
        last_grant_r <= grant_id_s;
      end
    end
  end

  // Tag pipeline trails the strobe so its last stage lines up with data LAT cycles later
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      tag_vld_r <= '0;
      for (int s = 0; s < LAT; s++) begin
        tag_id_r[s] <= '0;
      end
    end else begin
      tag_vld_r[0] <= mem_valid_r;
      tag_id_r[0]  <= mem_id_r;
      for (int s = 1; s < LAT; s++) begin
        tag_vld_r[s] <= tag_vld_r[s-1];
        tag_id_r[s]  <= tag_id_r[s-1];
      end
    end
  end

  // Response steering and activity indication
  always_comb begin
    resp_valid_out = '0;
    for (int i = 0; i < N; i++) begin
      resp_valid_out[i] = tag_vld_r[LAT-1] && (tag_id_r[LAT-1] == IW'(i));
    end
    busy_out = (|nonempty_s) | (|tag_vld_r) | mem_valid_r;
  end

  assign resp_data_out = mem_data_in;
  assign mem_req_out   = mem_req_r;
  assign mem_valid_out = mem_valid_r;
  assign overflow_out  = overflow_r;

endmodule

// File: tb/tb_graph_mem_arbiter.sv
// Directed bench for graph_mem_arbiter: a N=4/LAT=2 instance and a N=2/LAT=1 instance,
// each fed by a small read-only memory model returning a known function of the address.
module tb_graph_mem_arbiter;

  logic clk_in = 1'b0;
  logic rst_in = 1'b1;
  always #5 clk_in = ~clk_in;

  // main instance: N=4, LAT=2, QDEPTH=2
  logic [3:0]   req_valid;
  logic [127:0] req_addr;
  logic [3:0]   resp_valid;
  logic [31:0]  resp_data;
  logic [31:0]  mem_req;
  logic         mem_valid;
  logic [31:0]  mem_data;
  logic [3:0]   overflow;
  logic         busy;

  // second instance: N=2, LAT=1
  logic [1:0]  req2_valid;
  logic [63:0] req2_addr;
  logic [1:0]  resp2_valid;
  logic [31:0] resp2_data;
  logic [31:0] mem2_req;
  logic        mem2_valid;
  logic [31:0] mem2_data;
  logic [1:0]  overflow2;
  logic        busy2;

  int n_checks = 0;
  int n_fail   = 0;

  graph_mem_arbiter #(.N(4), .AW(32), .DW(32), .LAT(2), .QDEPTH(2)) dut (
    .clk_in(clk_in), .rst_in(rst_in),
    .req_valid_in(req_valid), .req_addr_in(req_addr),
    .resp_valid_out(resp_valid), .resp_data_out(resp_data),
    .mem_req_out(mem_req), .mem_valid_out(mem_valid), .mem_data_in(mem_data),
    .overflow_out(overflow), .busy_out(busy)
  );

  graph_mem_arbiter #(.N(2), .AW(32), .DW(32), .LAT(1), .QDEPTH(2)) dut2 (
    .clk_in(clk_in), .rst_in(rst_in),
    .req_valid_in(req2_valid), .req_addr_in(req2_addr),
    .resp_valid_out(resp2_valid), .resp_data_out(resp2_data),
    .mem_req_out(mem2_req), .mem_valid_out(mem2_valid), .mem_data_in(mem2_data),
    .overflow_out(overflow2), .busy_out(busy2)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0] ^ 16'hBEEF, a[15:0]};
  endfunction

  // memory models: data for the strobed address appears LAT cycles later
  logic [31:0] mpipe [2];
  logic [31:0] mpipe2;
  always @(posedge clk_in) begin
    mpipe[0] <= mem_word(mem_req);
    mpipe[1] <= mpipe[0];
    mpipe2   <= mem_word(mem2_req);
  end
  assign mem_data  = mpipe[1];
  assign mem2_data = mpipe2;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic wait_idle();
    for (int k = 0; k < 60 && busy; k++) tick();
    check("drain_timeout", {63'd0, busy}, 64'd0);
  endtask

  task automatic do_reset();
    rst_in = 1'b1;
    tick();
    tick();
    rst_in = 1'b0;
  endtask

  logic [31:0] exp_sim [4];
  logic [31:0] exp_fair [4];

  initial begin
    req_valid  = '0;
    req_addr   = '0;
    req2_valid = '0;
    req2_addr  = '0;
    do_reset();

    // reset state
    check("rst_mem_valid", {63'd0, mem_valid}, 64'd0);
    check("rst_mem_req", {32'd0, mem_req}, 64'd0);
    check("rst_overflow", {60'd0, overflow}, 64'd0);
    check("rst_resp_valid", {60'd0, resp_valid}, 64'd0);
    check("rst_busy", {63'd0, busy}, 64'd0);
    check("rst_busy2", {63'd0, busy2}, 64'd0);

    // single request from requester 2
    req_valid = 4'b0100;
    req_addr[64 +: 32] = 32'h10;
    tick();
    req_valid = '0;
    check("single_busy", {63'd0, busy}, 64'd1);
    check("single_no_early_strobe", {63'd0, mem_valid}, 64'd0);
    tick();
    check("single_strobe", {63'd0, mem_valid}, 64'd1);
    check("single_addr", {32'd0, mem_req}, 64'h10);
    tick();
    check("single_no_early_resp", {60'd0, resp_valid}, 64'd0);
    tick();
    check("single_resp_valid", {60'd0, resp_valid}, 64'b0100);
    check("single_resp_data", {32'd0, resp_data}, {32'd0, mem_word(32'h10)});
    tick();
    check("single_resp_done", {60'd0, resp_valid}, 64'd0);
    check("single_idle", {63'd0, busy}, 64'd0);

    // simultaneous requests from all four after reset
    do_reset();
    req_valid = 4'b1111;
    for (int i = 0; i < 4; i++) begin
      req_addr[i*32 +: 32] = 32'h100 + 32'(i);
      exp_sim[i] = 32'h100 + 32'(i);
    end
    tick();
    req_valid = '0;
    for (int t = 1; t <= 6; t++) begin
      tick();
      if (t <= 4) begin
        check("all4_grant_addr", {32'd0, mem_req}, {32'd0, exp_sim[t-1]});
        check("all4_strobe", {63'd0, mem_valid}, 64'd1);
      end else begin
        check("all4_strobe_off", {63'd0, mem_valid}, 64'd0);
      end
      if (t >= 3) begin
        check("all4_resp_onehot", {60'd0, resp_valid}, 64'd1 << (t - 3));
        check("all4_resp_data", {32'd0, resp_data}, {32'd0, mem_word(exp_sim[t-3])});
      end else begin
        check("all4_no_resp", {60'd0, resp_valid}, 64'd0);
      end
    end
    tick();
    check("all4_idle", {63'd0, busy}, 64'd0);

    // fairness: requesters 0 and 1 pulse every cycle for 20 cycles
    exp_fair[0] = 32'h200;
    exp_fair[1] = 32'h300;
    exp_fair[2] = 32'h201;
    exp_fair[3] = 32'h301;
    for (int j = 1; j <= 20; j++) begin
      req_valid = 4'b0011;
      req_addr[0 +: 32]  = 32'h200 + 32'(j - 1);
      req_addr[32 +: 32] = 32'h300 + 32'(j - 1);
      tick();
      if (j >= 2) begin
        check("fair_strobe", {63'd0, mem_valid}, 64'd1);
        check("fair_alternate", {60'd0, mem_req[11:8]}, (j % 2 == 0) ? 64'd2 : 64'd3);
      end
      if (j >= 2 && j <= 5) check("fair_addr", {32'd0, mem_req}, {32'd0, exp_fair[j-2]});
      if (j == 3) check("fair_no_early_overflow", {60'd0, overflow}, 64'd0);
    end
    req_valid = '0;
    check("fair_overflow", {60'd0, overflow}, 64'b0011);
    wait_idle();

    // full queue 3 pushed on the same edge it is granted
    do_reset();
    req_valid = 4'b1001;
    req_addr[0 +: 32]  = 32'h500;
    req_addr[96 +: 32] = 32'h400;
    tick();
    req_valid = 4'b1000;
    req_addr[96 +: 32] = 32'h401;
    tick();
    check("fwd_grant0", {32'd0, mem_req}, 64'h500);
    req_addr[96 +: 32] = 32'h402;
    tick();
    req_valid = '0;
    check("fwd_grant3a", {32'd0, mem_req}, 64'h400);
    check("fwd_no_overflow", {60'd0, overflow}, 64'd0);
    tick();
    check("fwd_grant3b", {32'd0, mem_req}, 64'h401);
    check("fwd_resp0", {60'd0, resp_valid}, 64'b0001);
    check("fwd_resp0_data", {32'd0, resp_data}, {32'd0, mem_word(32'h500)});
    tick();
    check("fwd_grant3c", {32'd0, mem_req}, 64'h402);
    for (int t = 0; t < 3; t++) begin
      if (t > 0) tick();
      check("fwd_resp3", {60'd0, resp_valid}, 64'b1000);
      check("fwd_resp3_data", {32'd0, resp_data}, {32'd0, mem_word(32'h400 + 32'(t))});
    end
    tick();
    check("fwd_idle", {63'd0, busy}, 64'd0);
    check("fwd_overflow_end", {60'd0, overflow}, 64'd0);

    // async reset while two reads are in flight
    req_valid = 4'b0011;
    req_addr[0 +: 32]  = 32'h600;
    req_addr[32 +: 32] = 32'h601;
    tick();
    req_valid = '0;
    tick();
    check("ar_grant0", {32'd0, mem_req}, 64'h600);
    tick();
    check("ar_grant1", {32'd0, mem_req}, 64'h601);
    #2;
    rst_in = 1'b1;
    #1;
    check("ar_mem_valid", {63'd0, mem_valid}, 64'd0);
    check("ar_mem_req", {32'd0, mem_req}, 64'd0);
    check("ar_resp", {60'd0, resp_valid}, 64'd0);
    check("ar_busy", {63'd0, busy}, 64'd0);
    tick();
    rst_in = 1'b0;
    for (int t = 0; t < 4; t++) begin
      tick();
      check("ar_no_stale_resp", {60'd0, resp_valid}, 64'd0);
    end
    req_valid = 4'b0111;
    req_addr[0 +: 32]  = 32'h700;
    req_addr[32 +: 32] = 32'h701;
    req_addr[64 +: 32] = 32'h702;
    tick();
    req_valid = '0;
    tick();
    check("ar_first_winner", {32'd0, mem_req}, 64'h700);
    tick();
    check("ar_second_winner", {32'd0, mem_req}, 64'h701);
    wait_idle();

    // N=2, LAT=1 instance: back-to-back requests from requester 1
    req2_valid = 2'b10;
    req2_addr[32 +: 32] = 32'h20;
    tick();
    req2_addr[32 +: 32] = 32'h21;
    tick();
    req2_valid = '0;
    check("l1_strobe", {63'd0, mem2_valid}, 64'd1);
    check("l1_addr0", {32'd0, mem2_req}, 64'h20);
    tick();
    check("l1_addr1", {32'd0, mem2_req}, 64'h21);
    check("l1_resp0", {62'd0, resp2_valid}, 64'b10);
    check("l1_resp0_data", {32'd0, resp2_data}, {32'd0, mem_word(32'h20)});
    tick();
    check("l1_resp1", {62'd0, resp2_valid}, 64'b10);
    check("l1_resp1_data", {32'd0, resp2_data}, {32'd0, mem_word(32'h21)});
    tick();
    check("l1_resp_done", {62'd0, resp2_valid}, 64'd0);
    check("l1_idle", {63'd0, busy2}, 64'd0);
    check("l1_overflow", {62'd0, overflow2}, 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
